spawn_scheduler: RTL and testbench

Consumer of the pseudo-random source (`random_out = lfsr % range + 6`). Each spawn takes two random draws: an inter-spawn delay in game ticks, then a lane index. The block counts down the delay and offers a spawn event over a valid/ready handshake to the object/playfield logic. It drives the source's `gen` and `range` inputs and sits between the LFSR and the playfield.

---
 rtl/spawn_pkg.sv | 15 +
 rtl/tick_down_counter.sv | 25 ++
 rtl/spawn_scheduler.sv | 79 +++++++
 tb/tb_spawn_scheduler.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/spawn_pkg.sv
// spawn_pkg: states, widths and the lane clamp shared by the spawn scheduler.
package spawn_pkg;
    localparam int RND_W = 5;
    localparam int LANE_W = 3;
    localparam logic [RND_W-1:0] RND_OFFSET = 5'd6;
    typedef enum logic [2:0] {
        S_IDLE, S_REQ_INT, S_LAT_INT, S_REQ_LANE, S_LAT_LANE, S_COUNT, S_EMIT
    } spawn_state_t;
    // Undo the source offset at 5 bits; values below the offset wrap high and clamp too.
    function automatic logic [LANE_W-1:0] clamp_lane(input logic [RND_W-1:0] r, input logic [RND_W-1:0] max_lane);
        logic [RND_W-1:0] d;
        d = r - RND_OFFSET;
        return LANE_W'(d > max_lane ? max_lane : d);
    endfunction
endpackage

// File: rtl/tick_down_counter.sv
// tick_down_counter: loadable down-counter stepping on qualified ticks, pulses zero on the 1->0 step.
module tick_down_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    input  logic         i_tick,
    input  logic         i_en,
    output logic         o_zero
);
    logic [W-1:0] r_count;
    logic         w_dec;
    assign w_dec  = i_tick && i_en;
    assign o_zero = w_dec && r_count == W'(1);
    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (i_load)
            r_count <= i_value;
        else if (w_dec)
            r_count <= r_count - W'(1);
    end
endmodule

// File: rtl/spawn_scheduler.sv
// spawn_scheduler: draws a delay and a lane from the random source, counts the delay
// down in game ticks and offers the spawn over valid/ready.
module spawn_scheduler
    import spawn_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int INT_RANGE = 8,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              tick,
    input  logic [RND_W-1:0]  rnd,
    output logic              gen,
    output logic [RND_W-1:0]  range,
    output logic              spawn_valid,
    input  logic              spawn_ready,
    output logic [LANE_W-1:0] spawn_lane,
    output logic [CNT_W-1:0]  spawn_count,
    output logic              busy
);
    spawn_state_t      r_state, w_next;
    logic              r_gen;
    logic [RND_W-1:0]  r_range;
    logic [LANE_W-1:0] r_lane;
    logic [CNT_W-1:0]  r_count;
    logic              w_zero;

    tick_down_counter #(.W(RND_W)) u_delay (
        .clk     (clk),
        .rst     (rst),
        .i_load  (r_state == S_LAT_INT),
        .i_value (rnd),
        .i_tick  (tick),
        .i_en    (enable && r_state == S_COUNT),
        .o_zero  (w_zero)
    );

    // Once a draw starts it runs to completion; only IDLE and COUNT look at enable.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = enable ? S_REQ_INT : S_IDLE;
            S_REQ_INT:  w_next = S_LAT_INT;
            S_LAT_INT:  w_next = S_REQ_LANE;
            S_REQ_LANE: w_next = S_LAT_LANE;
            S_LAT_LANE: w_next = S_COUNT;
            S_COUNT:    w_next = w_zero ? S_EMIT : S_COUNT;
            S_EMIT:     w_next = spawn_ready ? S_IDLE : S_EMIT;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gen   <= 1'b0;
            r_range <= RND_W'(INT_RANGE);
            r_lane  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_gen   <= w_next == S_REQ_INT || w_next == S_REQ_LANE;
            r_range <= w_next == S_REQ_INT ? RND_W'(INT_RANGE) : w_next == S_REQ_LANE ? RND_W'(NUM_LANES) : r_range;
            if (r_state == S_LAT_LANE)
                r_lane <= clamp_lane(rnd, RND_W'(NUM_LANES - 1));
            if (r_state == S_EMIT && spawn_ready)
                r_count <= r_count + CNT_W'(1);
        end
    end

    assign gen         = r_gen;
    assign range       = r_range;
    assign spawn_valid = r_state == S_EMIT;
    assign spawn_lane  = r_lane;
    assign spawn_count = r_count;
    assign busy        = r_state != S_IDLE;
endmodule

// File: tb/tb_spawn_scheduler.sv
// tb_spawn_scheduler: randomized spawn scenarios checked against a cycle-timeline model
// of draw order, tick-qualified countdown, lane clamping and handshake rules.
module tb_spawn_scheduler;
    localparam int NL = 4;
    localparam int IR = 8;

    logic       clk = 0, rst = 1, enable = 0, tick = 0, spawn_ready = 0;
    logic [4:0] rnd = 0;
    logic       gen, spawn_valid, busy;
    logic [4:0] range;
    logic [2:0] spawn_lane;
    logic [7:0] spawn_count;

    int pass = 0, total = 0, ngen = 0, rbad = 0, exp_count = 0;
    logic [4:0] q[$];

    spawn_scheduler #(.NUM_LANES(NL), .INT_RANGE(IR), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .tick(tick), .rnd(rnd), .gen(gen),
        .range(range), .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
        .spawn_lane(spawn_lane), .spawn_count(spawn_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Random source model: answers each gen with the next queued draw one cycle later.
    initial forever begin
        @(negedge clk);
        #1;
        if (range == 0) rbad++;
        if (gen) begin
            ngen++;
            if (q.size() > 0) rnd = q.pop_front();
            else rnd = 5'd6;
        end
    end

    // Runs one spawn from an IDLE cycle. mode 0: enable high, random ticks;
    // mode 1: random enable and ticks; mode 2: ticks every cycle, enable low in cycles 7..11.
    task automatic spawn(input int d, input int lraw, input int hold, input int mode, output int first_v);
        int k, rem, vcyc, el;
        bit done;
        q.push_back(5'(d));
        q.push_back(5'(lraw));
        el = (lraw >= 6 && lraw - 6 < NL) ? lraw - 6 : NL - 1;
        rem = d; vcyc = 0; first_v = 0; k = 0; done = 0;
        enable = 1; spawn_ready = 0; tick = (mode == 2) ? 1'b1 : 1'($urandom % 2);
        while (!done && k < 2000) begin
            @(negedge clk);
            k++;
            total++;
            if (gen !== (k == 1 || k == 3)) $display("FAIL gen cycle %0d: got %b want %b", k, gen, (k == 1 || k == 3));
            else pass++;
            if (k <= 4) begin
                total++;
                if (range !== (k <= 2 ? 5'(IR) : 5'(NL))) $display("FAIL range cycle %0d: got %0d want %0d", k, range, k <= 2 ? IR : NL);
                else pass++;
            end
            total++;
            if (busy !== 1'b1) $display("FAIL busy cycle %0d: got %b want 1", k, busy);
            else pass++;
            total++;
            if (spawn_valid !== (vcyc != 0 && k >= vcyc)) $display("FAIL valid cycle %0d: got %b want %b", k, spawn_valid, (vcyc != 0 && k >= vcyc));
            else pass++;
            total++;
            if (spawn_count !== 8'(exp_count)) $display("FAIL count_hold cycle %0d: got %0d want %0d", k, spawn_count, 8'(exp_count));
            else pass++;
            if (spawn_valid && first_v == 0) first_v = k;
            if (vcyc != 0 && k >= vcyc) begin
                total++;
                if (spawn_lane !== 3'(el)) $display("FAIL lane raw %0d: got %0d want %0d", lraw, spawn_lane, el);
                else pass++;
                if (k - vcyc >= hold) begin
                    spawn_ready = 1;
                    done = 1;
                end
            end
            tick = (mode == 2) ? 1'b1 : 1'($urandom % 2);
            enable = (mode == 1) ? ($urandom % 3 != 0) : (mode == 2) ? !(k >= 7 && k <= 11) : 1'b1;
            if (!done && vcyc == 0 && k >= 5 && tick && enable) begin
                rem--;
                if (rem == 0) vcyc = k + 1;
            end
        end
        if (!done) begin
            total++;
            $display("FAIL spawn_timeout: no acceptance within %0d cycles (valid got %b want 1)", k, spawn_valid);
            return;
        end
        @(negedge clk);
        exp_count++;
        spawn_ready = 0;
        total++;
        if (spawn_count !== 8'(exp_count)) $display("FAIL count_accept: got %0d want %0d", spawn_count, 8'(exp_count));
        else pass++;
        total++;
        if (spawn_valid !== 1'b0 || busy !== 1'b0) $display("FAIL post_accept: valid %b busy %b want 0 0", spawn_valid, busy);
        else pass++;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        total++; if (gen !== 1'b0) $display("FAIL reset_gen: got %b want 0", gen); else pass++;
        total++; if (spawn_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", spawn_valid); else pass++;
        total++; if (spawn_lane !== 3'd0) $display("FAIL reset_lane: got %0d want 0", spawn_lane); else pass++;
        total++; if (spawn_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", spawn_count); else pass++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass++;
        total++; if (range !== 5'(IR)) $display("FAIL reset_range: got %0d want %0d", range, IR); else pass++;
        rst = 0;
        exp_count = 0;
    endtask

    task automatic test_basic;
        int fv;
        spawn(9, 8, 0, 0, fv);
    endtask

    task automatic test_hold;
        int fv;
        spawn(6 + $urandom % IR, 7, 20, 1, fv);
    endtask

    task automatic test_freeze;
        int fv;
        spawn(6, 9, 0, 2, fv);
        total++;
        if (fv !== 16) $display("FAIL freeze_valid_cycle: got %0d want 16", fv);
        else pass++;
    endtask

    task automatic test_clamp;
        int vals[6] = '{31, 5, 6, 9, 10, 7};
        int fv;
        foreach (vals[i]) spawn(6 + $urandom % IR, vals[i], 0, 0, fv);
    endtask

    task automatic test_reset_mid;
        tick = 0;
        q.push_back(5'd3);
        q.push_back(5'd8);
        enable = 1;
        repeat (5) @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy); else pass++;
        rst = 1;
        @(negedge clk);
        rst = 0;
        enable = 0;
        exp_count = 0;
        total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else pass++;
        total++; if (spawn_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", spawn_valid); else pass++;
        total++; if (range !== 5'(IR)) $display("FAIL mid_range: got %0d want %0d", range, IR); else pass++;
        total++; if (spawn_lane !== 3'd0) $display("FAIL mid_lane: got %0d want 0", spawn_lane); else pass++;
        total++; if (spawn_count !== 8'd0) $display("FAIL mid_count: got %0d want 0", spawn_count); else pass++;
        repeat (4) begin
            tick = 1'($urandom % 2);
            @(negedge clk);
            total++;
            if (gen !== 1'b0 || busy !== 1'b0) $display("FAIL mid_idle: gen %b busy %b want 0 0", gen, busy);
            else pass++;
        end
    endtask

    task automatic test_back_to_back;
        int fv, g0;
        g0 = ngen;
        for (int n = 0; n < 256; n++)
            spawn(6 + $urandom % IR, ($urandom % 5 == 0) ? 31 : 6 + $urandom % NL, $urandom % 3, 0, fv);
        total++; if (spawn_count !== 8'd0) $display("FAIL wrap_count: got %0d want 0", spawn_count); else pass++;
        total++; if (ngen - g0 !== 512) $display("FAIL gen_total: got %0d want 512", ngen - g0); else pass++;
        total++; if (rbad !== 0) $display("FAIL range_zero: got %0d zero cycles want 0", rbad); else pass++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_hold;
        test_freeze;
        test_clamp;
        test_reset_mid;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
